// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types and constants for the gate self-test sequencer
package gate_bist_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  // Truth tables, bit v = expected output for input vector v
  localparam logic [7:0] AND3_TT = 8'h80;
  localparam logic [7:0] OR3_TT  = 8'hFE;

  // The count can reach 2^n (every vector failing), so it needs n+1 bits
  function automatic int err_count_w(input int n_inputs);
    return n_inputs + 1;
  endfunction

  // Settle counter holds SETTLE_CYCLES-1 at most; keep at least one bit
  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with a zero flag for the settle wait
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_selftest_seq.sv
// rtl/gate_selftest_seq.sv - exhaustive-vector self-test sequencer for an N-input gate
module gate_selftest_seq
  import gate_bist_pkg::*;
#(
  parameter int                        N_INPUTS      = 3,
  parameter int                        SETTLE_CYCLES = 4,
  parameter logic [(1<<N_INPUTS)-1:0]  EXPECT_TT     = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_INPUTS-1:0]   stim,
  input  logic                  dut_o,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_INPUTS:0]     err_count,
  output logic [N_INPUTS-1:0]   first_fail,
  output logic                  fail_valid
);

  localparam int                 NV       = 1 << N_INPUTS;
  localparam int                 EW       = err_count_w(N_INPUTS);
  localparam int                 CW       = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0]      RELOAD   = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(NV - 1);
  localparam logic [EW-1:0]      ERR_MAX  = EW'(NV);

  bist_state_e         r_state;
  bist_state_e         w_next_state;
  logic [N_INPUTS-1:0] r_vec;
  logic [N_INPUTS-1:0] r_stim;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [EW-1:0]       r_err;
  logic [N_INPUTS-1:0] r_first;
  logic                r_fvalid;

  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_accept;
  logic w_check;
  logic w_mismatch;
  logic w_active;

  settle_timer #(.W(CW)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (RELOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // A start is only accepted from IDLE and never alongside abort
  assign w_accept   = (r_state == ST_IDLE) && start && !abort;
  assign w_check    = (r_state == ST_CHECK) && !abort;
  assign w_mismatch = w_check && (dut_o != EXPECT_TT[r_vec]);
  assign w_active   = (r_state == ST_SETTLE) || (r_state == ST_CHECK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and timer control; abort overrides every transition
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next_state = ST_SETTLE;
            w_load       = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            w_next_state = ST_CHECK;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_CHECK: begin
          if (r_vec == LAST_VEC) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_SETTLE;
            w_load       = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Vector register: restarts at 0 on each run, advances after each non-terminal check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
    end else if (w_accept) begin
      r_vec <= '0;
    end else if (w_check && (r_vec != LAST_VEC)) begin
      r_vec <= r_vec + 1'b1;
    end
  end

  // Registered status outputs follow the state one cycle later; abort zeroes them at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (abort) begin
      r_stim <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_stim <= w_active ? r_vec : '0;
      r_busy <= w_active;
      r_done <= (r_state == ST_DONE);
    end
  end

  // Result registers: cleared on accepted start, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_first  <= '0;
      r_fvalid <= 1'b0;
    end else if (w_accept) begin
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_first  <= '0;
      r_fvalid <= 1'b0;
    end else begin
      if (w_mismatch) begin
        if (r_err != ERR_MAX) begin
          r_err <= r_err + 1'b1;
        end
        if (!r_fvalid) begin
          r_first  <= r_vec;
          r_fvalid <= 1'b1;
        end
      end
      if ((r_state == ST_DONE) && !abort) begin
        r_pass <= (r_err == '0);
      end
    end
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;
  assign fail_valid = r_fvalid;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// tb/tb_gate_selftest_seq.sv - self-checking bench for gate_selftest_seq
module tb_gate_selftest_seq;

  localparam int N  = 3;
  localparam int S  = 4;
  localparam int NV = 1 << N;
  localparam int L  = NV * (S + 1);
  localparam logic [7:0] TT0 = 8'h80;
  localparam logic [7:0] TT1 = 8'hFE;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;

  logic [N-1:0] d_stim  [2];
  logic         d_dut_o [2];
  logic         d_busy  [2];
  logic         d_done  [2];
  logic         d_pass  [2];
  logic [N:0]   d_err   [2];
  logic [N-1:0] d_first [2];
  logic         d_fv    [2];

  int       gate_sel;
  logic [7:0] rand_tt;
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  bit       chk_en = 1'b0;

  // Behavioural model state (shared timeline, per-instance results)
  bit           m_running;
  int           m_age;
  logic [N-1:0] m_stim  [2];
  logic         m_busy  [2];
  logic         m_done  [2];
  logic         m_pass  [2];
  logic [N:0]   m_err   [2];
  logic [N-1:0] m_first [2];
  logic         m_fv    [2];

  int          stim_seq [$];
  bit          cap_stim;

  function automatic logic gate_f(input int sel, input logic [7:0] rtt, input logic [N-1:0] x);
    case (sel)
      0:       return &x;
      1:       return |x;
      2:       return 1'b1;
      default: return rtt[x];
    endcase
  endfunction

  function automatic logic tt_bit(input int inst, input int v);
    logic [7:0] t;
    t = (inst == 0) ? TT0 : TT1;
    return t[v];
  endfunction

  assign d_dut_o[0] = gate_f(gate_sel, rand_tt, d_stim[0]);
  assign d_dut_o[1] = gate_f(gate_sel, rand_tt, d_stim[1]);

  gate_selftest_seq #(.N_INPUTS(N), .SETTLE_CYCLES(S), .EXPECT_TT(TT0)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stim(d_stim[0]), .dut_o(d_dut_o[0]), .busy(d_busy[0]), .done(d_done[0]),
    .pass(d_pass[0]), .err_count(d_err[0]), .first_fail(d_first[0]), .fail_valid(d_fv[0])
  );

  gate_selftest_seq #(.N_INPUTS(N), .SETTLE_CYCLES(S), .EXPECT_TT(TT1)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stim(d_stim[1]), .dut_o(d_dut_o[1]), .busy(d_busy[1]), .done(d_done[1]),
    .pass(d_pass[1]), .err_count(d_err[1]), .first_fail(d_first[1]), .fail_valid(d_fv[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a run is a timeline of L+1 edges after the accepting edge; vector v
  // occupies ages 1+v(S+1) .. (v+1)(S+1) and is judged at the last of those
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 1'b0;
      m_age     = 0;
      for (int i = 0; i < 2; i++) begin
        m_stim[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
        m_err[i] = '0; m_first[i] = '0; m_fv[i] = 1'b0;
      end
    end else if (abort) begin
      m_running = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_stim[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end
    end else if (!m_running) begin
      for (int i = 0; i < 2; i++) m_done[i] = 1'b0;
      if (start) begin
        m_running = 1'b1;
        m_age     = 0;
        for (int i = 0; i < 2; i++) begin
          m_pass[i] = 1'b0; m_err[i] = '0; m_first[i] = '0; m_fv[i] = 1'b0;
        end
      end
    end else begin
      m_age = m_age + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_age <= L) begin
          m_busy[i] = 1'b1;
          m_stim[i] = N'((m_age - 1) / (S + 1));
          if ((m_age % (S + 1)) == 0) begin
            int v;
            v = m_age / (S + 1) - 1;
            if (gate_f(gate_sel, rand_tt, N'(v)) != tt_bit(i, v)) begin
              m_err[i] = m_err[i] + 1'b1;
              if (!m_fv[i]) begin
                m_first[i] = N'(v);
                m_fv[i]    = 1'b1;
              end
            end
          end
        end else begin
          m_busy[i] = 1'b0;
          m_stim[i] = '0;
          m_done[i] = 1'b1;
          m_pass[i] = (m_err[i] == '0);
        end
      end
      if (m_age == L + 1) m_running = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare both instances with the model
  task automatic tick();
    @(negedge clk);
    if (cap_stim && d_busy[0] && ((stim_seq.size() == 0) || (stim_seq[$] != int'(d_stim[0]))))
      stim_seq.push_back(int'(d_stim[0]));
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (d_stim[i] !== m_stim[i] || d_busy[i] !== m_busy[i] || d_done[i] !== m_done[i] ||
            d_pass[i] !== m_pass[i] || d_err[i] !== m_err[i] || d_first[i] !== m_first[i] ||
            d_fv[i] !== m_fv[i]) begin
          errors++;
          $display("FAIL cycle_model inst%0d t=%0t dut/model: stim %0d/%0d busy %0b/%0b done %0b/%0b pass %0b/%0b err %0d/%0d first %0d/%0d fv %0b/%0b",
                   i, $time, d_stim[i], m_stim[i], d_busy[i], m_busy[i], d_done[i], m_done[i],
                   d_pass[i], m_pass[i], d_err[i], m_err[i], d_first[i], m_first[i], d_fv[i], m_fv[i]);
        end
      end
    end
  endtask

  task automatic pulse_start(output int k_cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    k_cyc = cyc;
  endtask

  task automatic wait_done(input string name, output int d_cyc);
    bit seen;
    seen  = 1'b0;
    d_cyc = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (d_done[0]) begin
        seen  = 1'b1;
        d_cyc = cyc;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done, required done within 200 cycles", name);
    end
  endtask

  task automatic chk_zero(input string name, input int i);
    chk({name, "_stim"}, int'(d_stim[i]), 0);
    chk({name, "_busy"}, int'(d_busy[i]), 0);
    chk({name, "_done"}, int'(d_done[i]), 0);
    chk({name, "_pass"}, int'(d_pass[i]), 0);
    chk({name, "_err"},  int'(d_err[i]), 0);
    chk({name, "_first"}, int'(d_first[i]), 0);
    chk({name, "_fv"},   int'(d_fv[i]), 0);
  endtask

  initial begin
    int k, d, ndone;
    bit ok;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gate_sel = 0; rand_tt = 8'h00; cap_stim = 1'b0;
    repeat (3) tick();
    chk_zero("reset_and", 0);
    chk_zero("reset_or", 1);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // AND3 gate against both tables
    gate_sel = 0;
    stim_seq.delete();
    cap_stim = 1'b1;
    pulse_start(k);
    wait_done("and3", d);
    cap_stim = 1'b0;
    chk("and3_done_latency", d - k, 41);
    chk("and3_stim_steps", stim_seq.size(), 8);
    ok = (stim_seq.size() == 8);
    foreach (stim_seq[j]) if (stim_seq[j] != j) ok = 1'b0;
    chk("and3_stim_order", int'(ok), 1);
    chk("and3_pass", int'(d_pass[0]), 1);
    chk("and3_err", int'(d_err[0]), 0);
    chk("and3_fv", int'(d_fv[0]), 0);
    chk("and3_vs_or_err", int'(d_err[1]), 6);
    chk("and3_vs_or_first", int'(d_first[1]), 1);
    chk("and3_vs_or_pass", int'(d_pass[1]), 0);
    repeat (3) tick();

    // Stuck-at-1 output
    gate_sel = 2;
    pulse_start(k);
    wait_done("stuck1", d);
    chk("stuck1_or_err", int'(d_err[1]), 1);
    chk("stuck1_or_first", int'(d_first[1]), 0);
    chk("stuck1_or_fv", int'(d_fv[1]), 1);
    chk("stuck1_or_pass", int'(d_pass[1]), 0);
    chk("stuck1_and_err", int'(d_err[0]), 7);
    tick();

    // Abort while vector 3 is on the inputs
    gate_sel = 0;
    pulse_start(k);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      tick();
      if (d_stim[0] == 3) ok = 1'b1;
    end
    chk("abort_reach_vec3", int'(ok), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_stim", int'(d_stim[0]), 0);
    chk("abort_busy", int'(d_busy[0]), 0);
    chk("abort_partial_err", int'(d_err[1]), 2);
    chk("abort_partial_first", int'(d_first[1]), 1);
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (d_done[0] || d_done[1]) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    pulse_start(k);
    tick();
    chk("restart_busy", int'(d_busy[1]), 1);
    chk("restart_stim", int'(d_stim[1]), 0);
    chk("restart_err", int'(d_err[1]), 0);
    chk("restart_fv", int'(d_fv[1]), 0);
    wait_done("restart", d);
    tick();

    // Start pulses during a run are ignored; start held over DONE begins a new run
    pulse_start(k);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    wait_done("held", d);
    chk("ignored_start_latency", d - k, 41);
    chk("held_done_busy", int'(d_busy[0]), 0);
    tick();
    chk("held_gap_done", int'(d_done[0]), 0);
    chk("held_gap_busy", int'(d_busy[0]), 0);
    tick();
    start = 1'b0;
    chk("held_rerun_busy", int'(d_busy[0]), 1);
    chk("held_rerun_stim", int'(d_stim[0]), 0);
    wait_done("held2", d);
    tick();

    // Asynchronous reset mid-SETTLE
    gate_sel = 2;
    pulse_start(k);
    repeat (7) tick();
    #8;
    rst_n = 1'b0;
    #1;
    chk_zero("areset_and", 0);
    chk_zero("areset_or", 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized runs with stray starts and occasional aborts
    for (int r = 0; r < 10; r++) begin
      int nrun;
      bit do_abort;
      gate_sel = $urandom_range(0, 3);
      rand_tt  = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      pulse_start(k);
      nrun     = $urandom_range(0, 60);
      do_abort = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < nrun; c++) begin
        start = ($urandom_range(0, 7) == 0);
        tick();
      end
      start = 1'b0;
      if (do_abort) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
        tick();
        if (!m_running) ok = 1'b1;
      end
      chk("random_run_ends", int'(ok), 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
